// File: rtl/conv_out_collector.sv
// rtl/conv_out_collector.sv - frame buffer sink for one conv output channel with max tracking and read port
module conv_out_collector #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 3,
    parameter int DEPTH  = 9,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pxl_in,
    input  logic              valid_in,
    input  logic              clear,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] row,
    output logic [ADDR_W-1:0] col,
    output logic              frame_done,
    output logic              overflow,
    output logic [DATA_W-1:0] max_val,
    output logic [ADDR_W-1:0] max_idx
);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    // Sized constants keep every compare and increment width-exact.
    localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]   col_q, col_d;
    logic                frame_done_q, frame_done_d;
    logic                overflow_q, overflow_d;
    logic [DATA_W-1:0]   max_val_q, max_val_d;
    logic [ADDR_W-1:0]   max_idx_q, max_idx_d;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_idx;

    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    // count never reaches DEPTH while writes are still accepted, so the low bits are the raster index.
    assign wr_idx = count_q[ADDR_W-1:0];

    // State and frame bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= COLLECT;
            count_q      <= '0;
            row_q        <= '0;
            col_q        <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            max_val_q    <= '0;
            max_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            row_q        <= row_d;
            col_q        <= col_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            max_val_q    <= max_val_d;
            max_idx_q    <= max_idx_d;
        end
    end

    // Next-state logic: clear dominates, COLLECT accepts pixels, FULL only flags overflow.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        row_d        = row_q;
        col_d        = col_q;
        frame_done_d = frame_done_q;
        overflow_d   = overflow_q;
        max_val_d    = max_val_q;
        max_idx_d    = max_idx_q;
        wr_en        = 1'b0;

        if (clear) begin
            state_d      = COLLECT;
            count_d      = '0;
            row_d        = '0;
            col_d        = '0;
            frame_done_d = 1'b0;
            overflow_d   = 1'b0;
            max_val_d    = '0;
            max_idx_d    = '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (valid_in) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CNT_ONE;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + IDX_ONE;
                        end else begin
                            col_d = col_q + IDX_ONE;
                        end
                        // Strict greater-than so ties keep the earliest index.
                        if ((count_q == '0) || (pxl_in > max_val_q)) begin
                            max_val_d = pxl_in;
                            max_idx_d = wr_idx;
                        end
                        if (count_q == LAST_CNT) begin
                            state_d      = FULL;
                            frame_done_d = 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (valid_in) begin
                        overflow_d = 1'b1;
                    end
                end
                default: begin
                    state_d = COLLECT;
                end
            endcase
        end
    end

    // Frame buffer storage; contents deliberately survive reset and clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= pxl_in;
        end
    end

    // Registered read port; nonblocking update gives read-before-write on a shared address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                if ({1'b0, rd_addr} >= DEPTH_CNT) begin
                    rd_data_q <= '0;
                end else begin
                    rd_data_q <= mem[rd_addr];
                end
            end
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign count      = count_q;
    assign row        = row_q;
    assign col        = col_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign max_val    = max_val_q;
    assign max_idx    = max_idx_q;

endmodule

// File: tb/tb_conv_out_collector.sv
// tb/tb_conv_out_collector.sv - scoreboard bench for conv_out_collector
module tb_conv_out_collector;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pxl_in = '0;
    logic        valid_in = 1'b0;
    logic        clear = 1'b0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [4:0]  count;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        frame_done;
    logic        overflow;
    logic [15:0] max_val;
    logic [3:0]  max_idx;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [15:0] exp_q [$];

    conv_out_collector dut (
        .clk        (clk),
        .reset      (reset),
        .pxl_in     (pxl_in),
        .valid_in   (valid_in),
        .clear      (clear),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .count      (count),
        .row        (row),
        .col        (col),
        .frame_done (frame_done),
        .overflow   (overflow),
        .max_val    (max_val),
        .max_idx    (max_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Read monitor: every rd_valid pops one expected word.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL rd_unexpected: got rd_valid=1 data 0x%0h expected no read", rd_data);
            end else begin
                chk("rd_data", int'(rd_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input logic [15:0] v);
        valid_in = 1'b1;
        pxl_in   = v;
        step();
        valid_in = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [15:0] e);
        rd_en   = 1'b1;
        rd_addr = a;
        exp_q.push_back(e);
        step();
        rd_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_row"}, int'(row), 0);
        chk({tag, "_col"}, int'(col), 0);
        chk({tag, "_done"}, int'(frame_done), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
        chk({tag, "_max"}, int'(max_val), 0);
        chk({tag, "_maxidx"}, int'(max_idx), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] fb [9];
        logic [15:0] fc [9];
        fb = '{16'd5, 16'd20, 16'd7, 16'd20, 16'd3, 16'd0, 16'd1, 16'd2, 16'd4};
        fc = '{16'h0100, 16'h0200, 16'h0300, 16'h0011, 16'h0500,
               16'h0600, 16'h0700, 16'h0800, 16'h0900};

        // Reset state
        #3;
        chk_zero("rst");
        chk("rst_rdv", int'(rd_valid), 0);
        chk("rst_rdd", int'(rd_data), 0);
        step();
        reset = 1'b0;
        step();

        // Frame A: 1..9 back to back
        for (int i = 0; i < 9; i++) begin
            chk("a_count", int'(count), i);
            chk("a_row", int'(row), i / 3);
            chk("a_col", int'(col), i % 3);
            chk("a_done_pre", int'(frame_done), 0);
            valid_in = 1'b1;
            pxl_in   = 16'(i + 1);
            step();
        end
        valid_in = 1'b0;
        chk("a_count9", int'(count), 9);
        chk("a_done", int'(frame_done), 1);
        chk("a_max", int'(max_val), 9);
        chk("a_maxidx", int'(max_idx), 8);
        chk("a_ovf", int'(overflow), 0);
        for (int i = 0; i < 9; i++) begin
            rd_en   = 1'b1;
            rd_addr = 4'(i);
            exp_q.push_back(16'(i + 1));
            step();
        end
        rd_en = 1'b0;
        step();
        chk("rdv_idle", int'(rd_valid), 0);
        chk("rdd_hold", int'(rd_data), 9);

        // Overflow on a 10th pixel
        px(16'hFFFF);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count", int'(count), 9);
        chk("ovf_max", int'(max_val), 9);
        chk("ovf_maxidx", int'(max_idx), 8);
        step();
        chk("ovf_sticky", int'(overflow), 1);
        rd(4'd0, 16'd1);
        do_clear();
        chk_zero("clr");

        // Frame B with idle gaps, tie on max
        for (int i = 0; i < 9; i++) begin
            px(fb[i]);
            for (int g = 0; g < (i % 3) + 1; g++) step();
        end
        chk("b_count", int'(count), 9);
        chk("b_done", int'(frame_done), 1);
        chk("b_max", int'(max_val), 20);
        chk("b_maxidx", int'(max_idx), 1);
        for (int i = 0; i < 9; i++) rd(4'(i), fb[i]);

        // clear wins over a simultaneous pixel
        do_clear();
        px(16'h0010);
        px(16'h0020);
        chk("c_count2", int'(count), 2);
        clear    = 1'b1;
        valid_in = 1'b1;
        pxl_in   = 16'h1234;
        step();
        clear    = 1'b0;
        valid_in = 1'b0;
        chk_zero("cv");
        px(16'h0042);
        chk("c_count1", int'(count), 1);
        chk("c_max", int'(max_val), 16'h0042);
        chk("c_maxidx", int'(max_idx), 0);
        rd(4'd0, 16'h0042);

        // Asynchronous reset after 4 pixels
        do_clear();
        for (int i = 0; i < 4; i++) px(16'h7000 + 16'(i));
        chk("r_count4", int'(count), 4);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("areset");
        #2;
        reset = 1'b0;
        step();
        for (int i = 0; i < 9; i++) px(fc[i]);
        chk("r_count9", int'(count), 9);
        chk("r_max", int'(max_val), 16'h0900);
        chk("r_maxidx", int'(max_idx), 8);
        for (int i = 0; i < 9; i++) rd(4'(i), fc[i]);

        // Out-of-range read
        rd(4'd12, 16'h0000);

        // Read-before-write on addr 3
        do_clear();
        px(16'h1111);
        px(16'h2222);
        px(16'h3333);
        valid_in = 1'b1;
        pxl_in   = 16'hABCD;
        rd_en    = 1'b1;
        rd_addr  = 4'd3;
        exp_q.push_back(16'h0011);
        step();
        valid_in = 1'b0;
        rd_en    = 1'b0;
        rd(4'd3, 16'hABCD);
        chk("w_count4", int'(count), 4);
        chk("w_max", int'(max_val), 16'hABCD);

        step();
        step();
        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/conv_out_collector.md
Name: conv_out_collector

Overview:
- Sink for the convolution engine's output stream: captures each 16-bit result flagged by `valid` into an on-chip frame buffer in raster order.
- Tracks frame completion, overflow and the running maximum (location included).
- Exposes a registered random-access read port so the host/testbench can dump the feature map after the frame completes.
- Sits directly downstream of `conv`; one instance per conv channel.

Parameters:
- DATA_W, 16, width of incoming result pixels, stored words and read data (unsigned).
- OUT_W, 3, output feature-map width/height (5x5 input, 3x3 kernel gives 3).
- DEPTH, 9, buffer words; must equal OUT_W*OUT_W.
- ADDR_W, 4, address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- pxl_in  input  DATA_W  result pixel from conv `pxl_out`.
- valid_in  input  1  qualifies pxl_in for one cycle (conv `valid`).
- clear  input  1  synchronous single-cycle pulse that re-arms the collector for a new frame.
- rd_en  input  1  read request.
- rd_addr  input  ADDR_W  raster index to read.
- rd_data  output  DATA_W  registered read data.
- rd_valid  output  1  high the cycle after an accepted rd_en.
- count  output  ADDR_W+1  pixels captured this frame.
- row  output  ADDR_W  row of the next write position.
- col  output  ADDR_W  column of the next write position.
- frame_done  output  1  level, all DEPTH pixels captured.
- overflow  output  1  sticky, valid_in seen while frame_done.
- max_val  output  DATA_W  largest pixel captured this frame.
- max_idx  output  ADDR_W  raster index of max_val.

Behaviour:
- Clock and reset: one clock (`clk`). Reset (`reset`) is asynchronous and active-high.
- Reset values: all outputs 0; state COLLECT. Buffer contents are not reset.
- State COLLECT:
  - Each cycle with valid_in=1, write pxl_in to buf[count] and increment count.
  - col increments; when col wraps from OUT_W-1 to 0, row increments.
  - Gaps in valid_in (any length) stall the counters with no effect.
- COLLECT -> FULL: on the write with count==DEPTH-1. On the next cycle count=DEPTH and frame_done=1, so frame_done rises 1 cycle after the final valid_in edge.
- State FULL:
  - valid_in is dropped (no buffer write, counters hold) and overflow is set.
  - overflow stays set until clear or reset.
- clear (either state):
  - Next cycle: state COLLECT; count, row, col, frame_done, overflow, max_val and max_idx all 0. Buffer is not erased.
  - clear and valid_in in the same cycle: clear wins and the pixel is dropped.
- Max tracking, updated on each accepted write (unsigned compare):
  - If count==0 or pxl_in > max_val: max_val <= pxl_in, max_idx <= current index.
  - Ties keep the earliest index.
- Read port:
  - Legal in any state. rd_en at edge N gives rd_data and rd_valid=1 after edge N+1 (1-cycle latency); rd_valid=0 otherwise.
  - rd_data holds its last value when rd_en=0.
  - rd_addr >= DEPTH returns 0 with rd_valid=1.
  - Read and write to the same address in the same cycle return the old contents (read-before-write).
- Reset mid-frame: immediate return to reset values. The next valid_in writes index 0.
- No backpressure: the collector accepts one pixel per cycle, matching conv's worst-case output rate.

Test Plan:
- Reset, then 9 valid_in pulses with pxl_in 1..9 back-to-back -> count 1..9, frame_done=1 one cycle after the 9th. Reads of addr 0..8 return 1..9 with rd_valid one cycle after each rd_en; max_val=9, max_idx=8; row/col sequence 0/0, 0/1, 0/2, 1/0, ...
- Same frame with 1–3 idle cycles between pixels, values {5,20,7,20,3,0,1,2,4} -> identical buffer contents; max_val=20, max_idx=1 (tie keeps earliest).
- After a full frame, a 10th valid_in with pxl_in=0xFFFF -> overflow=1 sticky, count stays 9, buf[0] unchanged, max unchanged. Then clear -> overflow=0, frame_done=0, count=0.
- clear and valid_in(pxl_in=0x1234) in the same cycle mid-frame -> count=0 next cycle. The next valid_in(0x0042) lands at addr 0; max_val=0x0042.
- Assert reset asynchronously mid-cycle after 4 pixels -> all outputs 0 immediately. The next 9 pixels fill addr 0..8 normally.
- Read addr 12 -> rd_data=0, rd_valid=1. Read addr 3 in the same cycle as the 4th write (value 0xABCD over old 0x0011) -> rd_data=0x0011; a re-read gives 0xABCD.
